// File: rtl/cpu_regfile_pkg.sv
// cpu_regfile_pkg: shared sizing helper, key field layout and vertex window slot names
package cpu_regfile_pkg;
  localparam int KEY_W = 4;
  localparam int KEY_UP = 3;
  localparam int KEY_DOWN = 2;
  localparam int KEY_LEFT = 1;
  localparam int KEY_RIGHT = 0;
  typedef enum int {V0, V1, V2, V3, V4, V5, V6, V7, VTX_RO} vtx_idx_e;
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic in_range(input int a, input int lo, input int n);
    return (a >= lo) && (a < lo + n);
  endfunction
endpackage

// File: rtl/cpu_regfile_mp_scoreboard.sv
// regfile_scoreboard: pending-write bits per register and the decode stall they raise
module regfile_scoreboard
  import cpu_regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter bit WR_BYPASS = 1,
  parameter bit ZERO_R0 = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     stall
);
  logic [NUM_REGS-1:0] pending, pending_nxt;
  logic byp;
  // write hits clear, a same-cycle issue re-sets; R0 is never pending when hardwired
  always_comb begin
    pending_nxt = pending;
    for (int w = 0; w < NUM_WR; w++)
      if (wr_en[w]) pending_nxt[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
    if (issue_valid) pending_nxt[issue_addr] = 1'b1;
    if (ZERO_R0) pending_nxt[0] = 1'b0;
  end
  // pending bit register
  always_ff @(posedge clk)
    if (rst) pending <= '0;
    else pending <= pending_nxt;
  // stall when a used read port hits a pending register not satisfied by bypass
  always_comb begin
    stall = 1'b0;
    byp = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      byp = 1'b0;
      for (int w = 0; w < NUM_WR; w++)
        byp = byp | (WR_BYPASS && wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == rd_addr[p*ADDR_W +: ADDR_W]));
      stall = stall | (rd_en[p] && pending[rd_addr[p*ADDR_W +: ADDR_W]] && !byp);
    end
  end
endmodule

// File: rtl/cpu_regfile_mp.sv
// cpu_regfile_mp: multi-port register file with scoreboard, VPU vertex window and sticky key capture
module cpu_regfile_mp
  import cpu_regfile_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int VTX_BASE = 23,
  parameter int VTX_CNT = 9,
  parameter int KEY_REG = 22,
  parameter int KEY_LSB = 3,
  parameter bit WR_BYPASS = 1,
  parameter bit ZERO_R0 = 0,
  localparam int ADDR_W = addr_w(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  input  logic [NUM_RD-1:0]         rd_en,
  output logic [NUM_RD*DATA_W-1:0]  rd_data,
  input  logic [NUM_WR-1:0]         wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]  wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]  wr_data,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_addr,
  output logic                      stall,
  input  logic                      vpu_start,
  input  logic                      vpu_we,
  input  logic [VTX_CNT*DATA_W-1:0] vpu_data,
  output logic [VTX_CNT*DATA_W-1:0] vtx_out,
  output logic                      vpu_lock,
  input  logic                      key_we,
  input  logic [KEY_W-1:0]          keys,
  output logic                      wr_conflict
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] nxt [NUM_REGS];
  logic conflict_c;
  // next array: CPU ports in index order, then VPU window load, then sticky key OR
  always_comb begin
    nxt = regs;
    conflict_c = 1'b0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && vpu_lock && in_range(int'(wr_addr[w*ADDR_W +: ADDR_W]), VTX_BASE, VTX_CNT))
        conflict_c = 1'b1;
      else if (wr_en[w])
        nxt[wr_addr[w*ADDR_W +: ADDR_W]] = wr_data[w*DATA_W +: DATA_W];
    end
    if (vpu_we)
      for (int v = 0; v < VTX_CNT; v++) nxt[VTX_BASE+v] = vpu_data[v*DATA_W +: DATA_W];
    if (key_we) nxt[KEY_REG][KEY_LSB +: KEY_W] = nxt[KEY_REG][KEY_LSB +: KEY_W] | keys;
    if (ZERO_R0) nxt[0] = '0;
  end
  // array, lock and conflict pulse state
  always_ff @(posedge clk)
    if (rst) begin
      regs <= '{default: '0};
      vpu_lock <= 1'b0;
      wr_conflict <= 1'b0;
    end else begin
      regs <= nxt;
      vpu_lock <= vpu_start ? 1'b1 : vpu_we ? 1'b0 : vpu_lock;
      wr_conflict <= conflict_c;
    end
  // read ports with optional same-cycle CPU write bypass, highest port wins
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data[p*DATA_W +: DATA_W] = regs[rd_addr[p*ADDR_W +: ADDR_W]];
      for (int w = 0; w < NUM_WR; w++)
        if (WR_BYPASS && wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == rd_addr[p*ADDR_W +: ADDR_W])
          rd_data[p*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
      if (ZERO_R0 && rd_addr[p*ADDR_W +: ADDR_W] == '0) rd_data[p*DATA_W +: DATA_W] = '0;
    end
  end
  // expose the vertex window
  always_comb begin
    vtx_out = '0;
    for (int v = 0; v < VTX_CNT; v++) vtx_out[v*DATA_W +: DATA_W] = regs[VTX_BASE+v];
  end
  regfile_scoreboard #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
    .WR_BYPASS(WR_BYPASS), .ZERO_R0(ZERO_R0)
  ) u_sb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_en(rd_en), .wr_en(wr_en), .wr_addr(wr_addr),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .stall(stall)
  );
endmodule

// File: tb/tb_cpu_regfile_mp.sv
// tb_cpu_regfile_mp: directed vector and sequence checks for cpu_regfile_mp
module tb_cpu_regfile_mp;
  localparam int DW = 16;
  localparam int AW = 5;
  localparam int VC = 9;
  logic clk = 1'b0;
  logic rst;
  logic [2*AW-1:0] rd_addr;
  logic [1:0] rd_en;
  logic [2*DW-1:0] rd_data;
  logic [1:0] wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic issue_valid;
  logic [AW-1:0] issue_addr;
  logic stall;
  logic vpu_start, vpu_we;
  logic [VC*DW-1:0] vpu_data, vtx_out;
  logic vpu_lock, key_we, wr_conflict;
  logic [3:0] keys;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [1:0] we;
    logic [4:0] wa0; logic [15:0] wd0;
    logic [4:0] wa1; logic [15:0] wd1;
    logic [4:0] ra0; logic [4:0] ra1;
    logic [15:0] e0; logic [15:0] e1;
  } vec_t;
  vec_t vt [7];
  logic [15:0] vd [VC];

  cpu_regfile_mp dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .stall(stall),
    .vpu_start(vpu_start), .vpu_we(vpu_we), .vpu_data(vpu_data), .vtx_out(vtx_out),
    .vpu_lock(vpu_lock), .key_we(key_we), .keys(keys), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rd_addr = '0; rd_en = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    issue_valid = 0; issue_addr = '0; vpu_start = 0; vpu_we = 0; vpu_data = '0;
    key_we = 0; keys = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    vt[0] = '{2'b11, 5'd5, 16'h1111, 5'd5, 16'h2222, 5'd5, 5'd6, 16'h2222, 16'h0006};
    vt[1] = '{2'b00, 5'd0, 16'h0000, 5'd0, 16'h0000, 5'd5, 5'd4, 16'h2222, 16'h0004};
    vt[2] = '{2'b11, 5'd10, 16'hABCD, 5'd11, 16'h1234, 5'd10, 5'd11, 16'hABCD, 16'h1234};
    vt[3] = '{2'b00, 5'd0, 16'h0000, 5'd0, 16'h0000, 5'd10, 5'd11, 16'hABCD, 16'h1234};
    vt[4] = '{2'b10, 5'd0, 16'h0000, 5'd0, 16'hFFFF, 5'd0, 5'd31, 16'hFFFF, 16'h001F};
    vt[5] = '{2'b00, 5'd0, 16'h0000, 5'd0, 16'h0000, 5'd0, 5'd5, 16'hFFFF, 16'h2222};
    vt[6] = '{2'b01, 5'd3, 16'h0033, 5'd3, 16'h9999, 5'd3, 5'd2, 16'h0033, 16'h0002};
    for (int v = 0; v < VC; v++) vd[v] = (v == VC - 1) ? 16'h00CC : 16'h00A0 + 16'(v);
    idle();
    rst = 1;
    tick();
    tick();
    rd_en = 2'b11;
    rd(5'd0, 5'd1);
    chk("reset_rd0", rd_data[15:0], 0);
    chk("reset_rd1", rd_data[31:16], 0);
    chk("reset_stall", stall, 0);
    chk("reset_lock", vpu_lock, 0);
    chk("reset_conflict", wr_conflict, 0);
    chk("reset_vtx", vtx_out[31:0], 0);
    rst = 0;
    idle();
    for (int i = 0; i < 32; i++) begin
      wr_en = 2'b01; wr_addr[4:0] = 5'(i); wr_data[15:0] = 16'(2 * i);
      tick();
    end
    idle();
    for (int i = 0; i < 32; i += 2) begin
      rd(5'(i), 5'(i + 1));
      chk("p0_fill_rd0", rd_data[15:0], 32'(2 * i));
      chk("p0_fill_rd1", rd_data[31:16], 32'(2 * i + 2));
    end
    for (int i = 0; i < 32; i++) begin
      wr_en = 2'b10; wr_addr[9:5] = 5'(i); wr_data[31:16] = 16'(i);
      tick();
    end
    idle();
    for (int i = 0; i < 32; i += 2) begin
      rd(5'(i), 5'(i + 1));
      chk("p1_fill_rd0", rd_data[15:0], 32'(i));
      chk("p1_fill_rd1", rd_data[31:16], 32'(i + 1));
    end
    for (int k = 0; k < 7; k++) begin
      idle();
      wr_en = vt[k].we;
      wr_addr = {vt[k].wa1, vt[k].wa0};
      wr_data = {vt[k].wd1, vt[k].wd0};
      rd(vt[k].ra0, vt[k].ra1);
      chk($sformatf("vec%0d_rd0", k), rd_data[15:0], vt[k].e0);
      chk($sformatf("vec%0d_rd1", k), rd_data[31:16], vt[k].e1);
      tick();
    end
    idle();
    issue_valid = 1; issue_addr = 5'd7;
    tick();
    idle();
    rd_en = 2'b01;
    rd(5'd7, 5'd0);
    chk("stall_pending", stall, 1);
    rd_en = 2'b00;
    #1;
    chk("stall_unused_port", stall, 0);
    rd_en = 2'b01; wr_en = 2'b01; wr_addr[4:0] = 5'd7; wr_data[15:0] = 16'h0042;
    #1;
    chk("stall_bypass", stall, 0);
    chk("bypass_r7", rd_data[15:0], 16'h0042);
    tick();
    idle();
    rd_en = 2'b01;
    rd(5'd7, 5'd0);
    chk("stall_cleared", stall, 0);
    chk("r7_written", rd_data[15:0], 16'h0042);
    issue_valid = 1; issue_addr = 5'd8; wr_en = 2'b01; wr_addr[4:0] = 5'd8; wr_data[15:0] = 16'h0808;
    tick();
    idle();
    rd_en = 2'b10;
    rd(5'd0, 5'd8);
    chk("set_clear_same", stall, 1);
    idle();
    vpu_start = 1;
    tick();
    idle();
    chk("lock_set", vpu_lock, 1);
    wr_en = 2'b01; wr_addr[4:0] = 5'd23; wr_data[15:0] = 16'hDEAD;
    issue_valid = 1; issue_addr = 5'd24;
    tick();
    idle();
    chk("conflict_pulse", wr_conflict, 1);
    rd(5'd23, 5'd0);
    chk("dropped_r23", rd_data[15:0], 16'h0017);
    wr_en = 2'b10; wr_addr[9:5] = 5'd24; wr_data[31:16] = 16'hBEEF;
    tick();
    idle();
    rd_en = 2'b01;
    rd(5'd24, 5'd0);
    chk("locked_clear_pending", stall, 0);
    chk("dropped_r24", rd_data[15:0], 16'h0018);
    tick();
    chk("conflict_one_cycle", wr_conflict, 0);
    vpu_we = 1;
    for (int v = 0; v < VC; v++) vpu_data[v*DW +: DW] = vd[v];
    tick();
    idle();
    chk("unlock", vpu_lock, 0);
    for (int v = 0; v < VC; v++) chk($sformatf("vtx%0d", v), vtx_out[v*DW +: DW], vd[v]);
    rd(5'd23, 5'd31);
    chk("rd_v0", rd_data[15:0], 16'h00A0);
    chk("rd_ro", rd_data[31:16], 16'h00CC);
    vpu_start = 1; vpu_we = 1;
    for (int v = 0; v < VC; v++) vpu_data[v*DW +: DW] = 16'h5000 + 16'(v);
    tick();
    idle();
    chk("start_we_lock", vpu_lock, 1);
    chk("start_we_v0", vtx_out[15:0], 16'h5000);
    chk("start_we_ro", vtx_out[(VC-1)*DW +: DW], 16'h5008);
    vpu_we = 1; vpu_data = '0;
    tick();
    idle();
    chk("we_release", vpu_lock, 0);
    key_we = 1; keys = 4'hF; wr_en = 2'b01; wr_addr[4:0] = 5'd22; wr_data[15:0] = 16'h0001;
    tick();
    idle();
    rd(5'd22, 5'd0);
    chk("key_or_write", rd_data[15:0], 16'h0079);
    key_we = 1; keys = 4'h0;
    tick();
    idle();
    rd(5'd22, 5'd0);
    chk("key_sticky", rd_data[15:0], 16'h0079);
    wr_en = 2'b01; wr_addr[4:0] = 5'd22; wr_data[15:0] = 16'h0000;
    tick();
    idle();
    key_we = 1; keys = 4'h2;
    tick();
    idle();
    rd(5'd22, 5'd0);
    chk("key_after_clear", rd_data[15:0], 16'h0010);
    vpu_start = 1; vpu_we = 1;
    for (int v = 0; v < VC; v++) vpu_data[v*DW +: DW] = 16'h7700 + 16'(v);
    tick();
    idle();
    wr_en = 2'b01; wr_addr[4:0] = 5'd25; wr_data[15:0] = 16'h1234;
    issue_valid = 1; issue_addr = 5'd9;
    tick();
    idle();
    chk("pre_reset_lock", vpu_lock, 1);
    chk("pre_reset_conflict", wr_conflict, 1);
    rd_en = 2'b01;
    rd(5'd9, 5'd0);
    chk("pre_reset_stall", stall, 1);
    rst = 1;
    tick();
    rst = 0;
    idle();
    rd_en = 2'b11;
    rd(5'd9, 5'd22);
    chk("rst_lock", vpu_lock, 0);
    chk("rst_conflict", wr_conflict, 0);
    chk("rst_stall", stall, 0);
    chk("rst_r9", rd_data[15:0], 0);
    chk("rst_r22", rd_data[31:16], 0);
    chk("rst_vtx_lo", vtx_out[31:0], 0);
    chk("rst_vtx_ro", vtx_out[(VC-1)*DW +: DW], 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
